// File: rtl/link_pkg.sv
// Shared types and constants for the link receive buffer.
// Holds the handshake state type and the default sizing constants.
package link_pkg;
    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } link_state_t;

    localparam int LINK_DATA_W    = 8;
    localparam int LINK_DEPTH     = 4;
    localparam int LINK_FRAME_LEN = 4;
endpackage

// File: rtl/link_rx_buf_if.sv
// Four-phase request/acknowledge link between the initiator and the receive buffer.
interface link_rx_buf_if;
    import link_pkg::*;

    logic                   req;
    logic [LINK_DATA_W-1:0] data_in;
    logic                   ack;

    modport master (output req, output data_in, input ack);
    modport slave  (input req, input data_in, output ack);
endinterface

// File: rtl/link_fifo.sv
// Byte FIFO with first-word-fall-through read; storage is deliberately left unreset.
module link_fifo
    import link_pkg::*;
#(
    parameter int DEPTH = LINK_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [LINK_DATA_W-1:0] wr_data,
    input  logic                   rd_en,
    output logic [LINK_DATA_W-1:0] rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [LINK_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   push;
    logic                   pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop     = rd_en && !empty;
    // A write into a full FIFO is legal when a pop frees the head slot on the same edge.
    assign push    = wr_en && (!full || pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/link_rx_buf.sv
// Link receive buffer: four-phase handshake front end feeding a byte FIFO,
// with per-frame byte counting and a saturating completed-frame counter.
module link_rx_buf
    import link_pkg::*;
#(
    parameter int DEPTH     = LINK_DEPTH,
    parameter int FRAME_LEN = LINK_FRAME_LEN
) (
    input  logic                   clk,
    input  logic                   rst_n,
    link_rx_buf_if.slave           lnk,
    input  logic                   rd_en,
    output logic [LINK_DATA_W-1:0] rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   last_byte,
    output logic [7:0]             frame_cnt
);
    localparam int            BW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_LEN - 1);

    link_state_t   state;
    logic          ack_q;
    logic [BW-1:0] byte_cnt;
    logic          accept;

    // When full, the FIFO is necessarily non-empty, so rd_en alone guarantees a pop.
    assign accept  = (state == IDLE) && lnk.req && (!full || rd_en);
    assign lnk.ack = ack_q;

    link_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_data (lnk.data_in),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ack_q     <= 1'b0;
            byte_cnt  <= '0;
            last_byte <= 1'b0;
            frame_cnt <= '0;
        end else begin
            last_byte <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ACKED;
                        ack_q <= 1'b1;
                        if (byte_cnt == LAST_IDX) begin
                            byte_cnt  <= '0;
                            last_byte <= 1'b1;
                            if (frame_cnt != 8'hFF) begin
                                frame_cnt <= frame_cnt + 1'b1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                ACKED: begin
                    if (!lnk.req) begin
                        state <= IDLE;
                        ack_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ack_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_link_rx_buf.sv
// Directed bench for link_rx_buf with DEPTH=4, FRAME_LEN=4.
module tb_link_rx_buf;
    logic       clk;
    logic       rst_n;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       last_byte;
    logic [7:0] frame_cnt;

    int n_tests;
    int n_fail;

    link_rx_buf_if lnk ();

    link_rx_buf #(
        .DEPTH     (4),
        .FRAME_LEN (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lnk       (lnk),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .last_byte (last_byte),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        lnk.req     = 1'b0;
        lnk.data_in = 8'h00;
        rd_en       = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // One full four-phase handshake; data_in is corrupted while ACKED to show it is ignored.
    task automatic hs(input logic [7:0] b);
        bit got;
        got         = 1'b0;
        lnk.req     = 1'b1;
        lnk.data_in = b;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (lnk.ack) got = 1'b1;
        end
        if (!got) chk("hs_timeout", 32'd0, 32'd1);
        lnk.data_in = 8'hEE;
        step();
        lnk.req = 1'b0;
        step();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    logic [7:0] frame_bytes [4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        frame_bytes[0] = 8'h11;
        frame_bytes[1] = 8'h22;
        frame_bytes[2] = 8'h33;
        frame_bytes[3] = 8'h44;

        // Reset state
        do_reset();
        chk("rst_ack", lnk.ack, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_last", last_byte, 1'b0);
        chk("rst_frames", frame_cnt, 8'd0);

        // Single byte handshake
        lnk.req     = 1'b1;
        lnk.data_in = 8'hA5;
        chk("sb_ack_pre", lnk.ack, 1'b0);
        step();
        chk("sb_ack_rise", lnk.ack, 1'b1);
        chk("sb_count", count, 3'd1);
        chk("sb_data", rd_data, 8'hA5);
        step();
        chk("sb_ack_hold", lnk.ack, 1'b1);
        chk("sb_count_once", count, 3'd1);
        lnk.req = 1'b0;
        step();
        chk("sb_ack_fall", lnk.ack, 1'b0);
        chk("sb_count_end", count, 3'd1);
        pop();
        chk("sb_empty", empty, 1'b1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("pop_empty_count", count, 3'd0);
        chk("pop_empty_empty", empty, 1'b1);

        // Frame of four bytes, no reads
        do_reset();
        for (int i = 0; i < 4; i++) begin
            lnk.req     = 1'b1;
            lnk.data_in = frame_bytes[i];
            step();
            chk("fr_ack", lnk.ack, 1'b1);
            chk("fr_last", last_byte, (i == 3));
            lnk.req = 1'b0;
            step();
            chk("fr_last_clr", last_byte, 1'b0);
            chk("fr_ack_fall", lnk.ack, 1'b0);
        end
        chk("fr_frames", frame_cnt, 8'd1);
        chk("fr_full", full, 1'b1);
        chk("fr_count", count, 3'd4);

        // Backpressure while full, then release with a single pop
        lnk.req     = 1'b1;
        lnk.data_in = 8'h55;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ack_low", lnk.ack, 1'b0);
            chk("bp_count", count, 3'd4);
        end
        chk("bp_head", rd_data, 8'h11);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("bp_ack_rise", lnk.ack, 1'b1);
        chk("bp_count_kept", count, 3'd4);
        lnk.req = 1'b0;
        step();
        for (int i = 1; i < 4; i++) begin
            chk("fr_pop_data", rd_data, frame_bytes[i]);
            pop();
        end
        chk("bp_pop_data", rd_data, 8'h55);
        pop();
        chk("bp_empty", empty, 1'b1);

        // Simultaneous write and pop
        do_reset();
        hs(8'hA1);
        hs(8'hA2);
        chk("sim_count_pre", count, 3'd2);
        lnk.req     = 1'b1;
        lnk.data_in = 8'hA3;
        rd_en       = 1'b1;
        chk("sim_head", rd_data, 8'hA1);
        step();
        rd_en = 1'b0;
        chk("sim_ack", lnk.ack, 1'b1);
        chk("sim_count", count, 3'd2);
        chk("sim_next", rd_data, 8'hA2);
        lnk.req = 1'b0;
        step();
        pop();
        chk("sim_last", rd_data, 8'hA3);
        pop();
        chk("sim_empty", empty, 1'b1);

        // Pointer wrap: ten write/pop pairs through a 4-deep FIFO
        do_reset();
        for (int i = 0; i < 10; i++) begin
            hs(8'(i));
            chk("wrap_data", rd_data, 32'(i));
            pop();
        end
        chk("wrap_frames", frame_cnt, 8'd2);
        chk("wrap_bytecnt", dut.byte_cnt, 2'd2);
        chk("wrap_empty", empty, 1'b1);

        // Asynchronous reset while ACKED, req held high across release
        lnk.req     = 1'b1;
        lnk.data_in = 8'h77;
        step();
        chk("ar_ack_pre", lnk.ack, 1'b1);
        chk("ar_count_pre", count, 3'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ack", lnk.ack, 1'b0);
        chk("ar_empty", empty, 1'b1);
        chk("ar_frames", frame_cnt, 8'd0);
        step();
        rst_n       = 1'b1;
        lnk.data_in = 8'h78;
        step();
        chk("ar_new_ack", lnk.ack, 1'b1);
        chk("ar_new_count", count, 3'd1);
        chk("ar_new_data", rd_data, 8'h78);
        lnk.req = 1'b0;
        step();

        // Frame counter saturation
        do_reset();
        for (int i = 0; i < 1024; i++) begin
            hs(8'(i));
            pop();
            if (i == 1019) chk("sat_255", frame_cnt, 8'd255);
        end
        chk("sat_hold", frame_cnt, 8'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/link_rx_buf.md
LINK_RX_BUF -- requirements
Module: link_rx_buf

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in bytes; SHALL be a power of two, at least 2.
REQ-002 Parameter FRAME_LEN, default 4, number of bytes per frame; SHALL be at least 1.
REQ-003 clk  input  1  single clock; every flop SHALL be rising-edge clk.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req  input  1  four-phase request from the link initiator, synchronous to clk.
REQ-006 data_in  input  8  byte from the initiator, valid while req=1.
REQ-007 ack  output  1  four-phase acknowledge to the initiator.
REQ-008 rd_en  input  1  consumer pop strobe.
REQ-009 rd_data  output  8  FIFO head byte, first-word-fall-through.
REQ-010 empty  output  1  FIFO holds 0 bytes.
REQ-011 full  output  1  FIFO holds DEPTH bytes.
REQ-012 count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-013 last_byte  output  1  one-cycle pulse on acceptance of the final byte of a frame.
REQ-014 frame_cnt  output  8  completed frames, saturating at 255.

Function
REQ-015 The handshake FSM SHALL have exactly two states: IDLE (ack=0) and ACKED (ack=1); ack SHALL be a registered output.
REQ-016 In IDLE, if req=1 and space exists (count<DEPTH, or count=DEPTH with a pop in the same cycle), the block SHALL write data_in to the FIFO and move to ACKED at that edge.
REQ-017 In IDLE with req=1 and no space, the block SHALL stay in IDLE, keep ack=0, and write nothing; this backpressure SHALL last until space exists.
REQ-018 In ACKED, the block SHALL stay while req=1 and SHALL return to IDLE on the first edge that samples req=0.
REQ-019 Latency: with req sampled high at edge N, ack=1 SHALL be visible after edge N; with req sampled low at edge M, ack=0 SHALL be visible after edge M.
REQ-020 A byte SHALL be written exactly once per handshake; data_in SHALL be ignored in ACKED.
REQ-021 A pop (rd_en=1 and empty=0) SHALL advance the read pointer; rd_en while empty SHALL be ignored and no state SHALL change.
REQ-022 A simultaneous write and pop SHALL leave count unchanged; the pop SHALL return the old head.
REQ-023 Pointers SHALL wrap modulo DEPTH; full and empty SHALL derive from count.
REQ-024 When empty=1, rd_data SHALL be don't-care; when empty=0, it SHALL equal the oldest stored byte.
REQ-025 A byte counter (0..FRAME_LEN-1) SHALL increment on each write and wrap to 0 after FRAME_LEN-1.
REQ-026 last_byte SHALL be 1 in the cycle after the edge that writes the byte taking the counter from FRAME_LEN-1 to 0, then return to 0.
REQ-027 On each such wrap, frame_cnt SHALL increment, holding at 255.

Reset
REQ-028 rst_n=0 SHALL immediately force: FSM=IDLE, ack=0, pointers=0, count=0, empty=1, full=0, byte counter=0, last_byte=0, frame_cnt=0.
REQ-029 FIFO storage SHALL NOT be reset; rd_data after reset SHALL be don't-care.
REQ-030 Reset mid-handshake (ACKED) SHALL drop ack immediately; after release, a still-high req SHALL be treated as a new request.

Structure
REQ-031 A shared package link_pkg SHALL hold the FSM state type (IDLE, ACKED), LINK_DATA_W=8, and the default DEPTH and FRAME_LEN constants.
REQ-032 FIFO storage, pointers and count SHALL live in one sub-module, link_fifo; the handshake FSM and frame counter SHALL live in link_rx_buf.

Verification
REQ-033 Single byte: req=1 with data_in=0xA5 held until ack, then req=0 -> ack rises 1 cycle after req, falls 1 cycle after req=0; count=1; rd_data=0xA5.
REQ-034 Frame: 4 handshakes carrying 0x11,0x22,0x33,0x44 with no reads -> last_byte pulses once on the 0x44 write; frame_cnt=1; full=1; pops return 0x11..0x44 in order.
REQ-035 Backpressure: FIFO full, req=1 -> ack stays 0 for 5 cycles; single rd_en -> byte written and ack rises in that same cycle's edge; count stays 4.
REQ-036 Simultaneous: count=2 and rd_en=1 in the write cycle -> count stays 2; correct head popped.
REQ-037 Wrap: 10 write/pop pairs of 0x00..0x09 through DEPTH=4 -> data order preserved; frame_cnt=2 and byte counter=2.
REQ-038 Reset in ACKED: rst_n low -> ack=0, empty=1, frame_cnt=0 asynchronously; req held high through release -> new byte accepted.
